// File: rtl/rom_prefetch_window.sv
// rom_prefetch_window
//
// Purpose: sits between the cartridge ROM port and the QSPI flash controller.
// It keeps a sliding window of DEPTH consecutive ROM bytes fetched by one
// sequential flash stream. Hits are served with one cycle of latency. Misses
// raise rom_wait, and the stream is started, stalled, stopped or restarted
// as needed.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   rom_read          CPU presents a valid ROM address this cycle
//   rom_address       CPU ROM address (ADDR_BITS)
//   rom_data          registered read data
//   rom_wait          requested byte not yet in the window (combinational)
//   flash_addr        stream start address (FLASH_BASE + rom_address)
//   flash_start       1-cycle pulse: begin a stream at flash_addr
//   flash_stop        1-cycle pulse: abort the current stream
//   flash_stall       hold the stream; no new byte may be delivered
//   flash_data        byte from the controller
//   flash_data_ready  level; each rising edge delivers one byte
//   flash_busy        controller has an active transaction
//
// Optional feature (macro ROM_PREFETCH_STATS_EN): adds saturating 16-bit
// hit_count / miss_count outputs.
module rom_prefetch_window #(
  parameter int          ADDR_BITS  = 12,
  parameter int          DEPTH      = 4,
  parameter logic [23:0] FLASH_BASE = 24'h100000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rom_read,
  input  logic [ADDR_BITS-1:0] rom_address,
  output logic [7:0]           rom_data,
  output logic                 rom_wait,
  output logic [23:0]          flash_addr,
  output logic                 flash_start,
  output logic                 flash_stop,
  output logic                 flash_stall,
  input  logic [7:0]           flash_data,
  input  logic                 flash_data_ready,
  input  logic                 flash_busy
`ifdef ROM_PREFETCH_STATS_EN
  ,
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count
`endif
);

  localparam int IDX_BITS = $clog2(DEPTH);
  localparam int CNT_BITS = IDX_BITS + 1;
  localparam logic [CNT_BITS-1:0]  FULL_CNT = CNT_BITS'(DEPTH);
  localparam logic [ADDR_BITS:0]   WRAP_END = {1'b1, {ADDR_BITS{1'b0}}};

  typedef enum logic [1:0] {IDLE, FILL, STOPPING} state_e;

  state_e                state_q, state_d;
  logic [ADDR_BITS-1:0]  win_base_q, win_base_d;
  logic [CNT_BITS-1:0]   count_q, count_d;
  logic [23:0]           addr_q, addr_d;
  logic                  start_q, start_d;
  logic                  stop_q, stop_d;
  logic                  stall_q, stall_d;
  logic                  ready_last_q, busy_last_q;
  logic [7:0]            rom_data_q;
  logic [7:0]            slot_q [DEPTH];

  logic [ADDR_BITS-1:0]  offset, count_ext;
  logic [ADDR_BITS:0]    end_addr;
  logic                  hit, nxt, at_end, full, retire, rising;
  logic                  capture_ok, capture, start_req;
  logic [IDX_BITS-1:0]   wr_idx;

  assign count_ext = ADDR_BITS'(count_q);
  assign offset    = rom_address - win_base_q;
  assign hit       = rom_read && (offset < count_ext);
  // The stream runs linearly past the top of ROM, so once the window ends at
  // the last address no further byte belongs to it and "next" is impossible.
  assign end_addr  = {1'b0, win_base_q} + (ADDR_BITS + 1)'(count_q);
  assign at_end    = (end_addr == WRAP_END);
  assign nxt       = rom_read && (offset == count_ext) && (state_q == FILL) && !at_end;
  assign full      = (count_q == FULL_CNT);
  assign retire    = full && hit && (offset != '0);
  assign rising    = flash_data_ready && !ready_last_q;
  // With a retire the new byte reuses the slot of the byte being retired.
  assign capture_ok = (state_q == FILL) && rising && !at_end && (!full || retire);
  assign wr_idx    = IDX_BITS'(win_base_q + count_ext);

  assign rom_wait    = rom_read && !hit;
  assign rom_data    = rom_data_q;
  assign flash_addr  = addr_q;
  assign flash_start = start_q;
  assign flash_stop  = stop_q;
  assign flash_stall = stall_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    win_base_d = win_base_q;
    count_d    = count_q;
    addr_d     = addr_q;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    capture    = 1'b0;
    start_req  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rom_read && !hit) start_req = 1'b1;
      end
      FILL: begin
        if (rom_read && !hit && !nxt) begin
          // Stop wins over a same-cycle capture; the byte is dropped.
          stop_d  = 1'b1;
          state_d = STOPPING;
        end else begin
          capture = capture_ok;
          if (busy_last_q && !flash_busy) state_d = IDLE;
        end
      end
      STOPPING: begin
        // Never restart while the aborted transaction is still winding down.
        if (!flash_busy) begin
          if (rom_read && !hit) start_req = 1'b1;
          else                  state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_req) begin
      start_d    = 1'b1;
      addr_d     = FLASH_BASE + 24'(rom_address);
      win_base_d = rom_address;
      count_d    = '0;
      state_d    = FILL;
    end else begin
      if (retire) win_base_d = win_base_q + ADDR_BITS'(1);
      if (retire && !capture)      count_d = count_q - CNT_BITS'(1);
      else if (!retire && capture) count_d = count_q + CNT_BITS'(1);
    end

    stall_d = (count_d == FULL_CNT) || (state_d != FILL);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      win_base_q   <= '0;
      count_q      <= '0;
      addr_q       <= '0;
      start_q      <= 1'b0;
      stop_q       <= 1'b0;
      stall_q      <= 1'b0;
      ready_last_q <= 1'b0;
      busy_last_q  <= 1'b0;
      rom_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      win_base_q   <= win_base_d;
      count_q      <= count_d;
      addr_q       <= addr_d;
      start_q      <= start_d;
      stop_q       <= stop_d;
      stall_q      <= stall_d;
      ready_last_q <= flash_data_ready;
      busy_last_q  <= flash_busy;
      if (hit) rom_data_q <= slot_q[rom_address[IDX_BITS-1:0]];
    end
  end

  // NOTE: the byte store is not reset; a slot is only read after count
  // covers it, and leaving it unreset lets it map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (capture) slot_q[wr_idx] <= flash_data;
  end

`ifdef ROM_PREFETCH_STATS_EN
  logic [15:0] hit_count_q, miss_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (hit && (hit_count_q != 16'hFFFF))        hit_count_q  <= hit_count_q + 16'd1;
      if (start_req && (miss_count_q != 16'hFFFF)) miss_count_q <= miss_count_q + 16'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: doc/rom_prefetch_window.md
Name: rom_prefetch_window

Overview:
- Sits between the atari2600 cartridge ROM port and qspi_flash_controller.
- Turns random CPU ROM reads into sequential QSPI streams.
- Holds a sliding window of DEPTH consecutive ROM bytes, serves hits with 1-cycle latency, and raises a wait on misses.
- Controls the flash stream: start, stall when the window is full, stop and restart on a miss outside the window.

Parameters:
- ADDR_BITS, 12, cartridge address width.
- DEPTH, 4, window size in bytes; power of two, 2..16.
- FLASH_BASE, 24'h100000, flash byte offset of cartridge address 0.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rom_read  in  1  valid ROM address on bus this cycle
- rom_address  in  ADDR_BITS  CPU ROM address
- rom_data  out  8  registered read data
- rom_wait  out  1  requested byte not yet available; system must stall
- flash_addr  out  24  stream start address to controller
- flash_start  out  1  1-cycle pulse: begin read at flash_addr
- flash_stop  out  1  1-cycle pulse: abort current stream
- flash_stall  out  1  hold stream; no new byte may be delivered
- flash_data  in  8  byte from controller
- flash_data_ready  in  1  level; each rising edge delivers one new byte
- flash_busy  in  1  controller has an active transaction

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values:
  - rom_data=0, rom_wait=0 (combinational, see below).
  - flash_start=0, flash_stop=0, flash_stall=0, flash_addr=0.
  - Window: win_base=0, count=0; state=IDLE; ready_last=0.
- Window:
  - Bytes win_base..win_base+count-1, stored in slot addr[log2(DEPTH)-1:0].
  - offset = (rom_address - win_base) mod 2^ADDR_BITS.
  - hit = rom_read && offset<count.
  - next = rom_read && offset==count && state==FILL.
- Outputs:
  - rom_wait = rom_read && !hit (combinational).
  - On a hit, rom_data <= slot[rom_address] at the next edge (latency 1).
  - On a miss, rom_data holds its value.
- Byte capture:
  - Triggered when flash_data_ready && !ready_last, in FILL.
  - Write slot[win_base+count]; count += 1.
  - Capture and a same-cycle hit on that byte: rom_wait stays high that cycle; the hit occurs next cycle.
- States:
  - IDLE:
    - rom_read && !hit → pulse flash_start.
    - flash_addr = FLASH_BASE + zero-extended rom_address.
    - win_base <= rom_address; count <= 0 → FILL.
  - FILL:
    - hit or next → no action (next simply waits).
    - rom_read, !hit, !next → pulse flash_stop → STOPPING.
    - flash_busy falling with no pending miss → IDLE (window retained).
  - STOPPING: wait until flash_busy==0, then start a new read as in IDLE for the current rom_address → FILL. If rom_read dropped, go to IDLE.
- Full window and slide:
  - flash_stall = (count==DEPTH) || state!=FILL (registered, updated the same edge count changes).
  - When count==DEPTH and a hit occurs with offset>=1: retire the oldest byte (win_base += 1, count -= 1). At most one retire per cycle.
  - Retire and capture in the same cycle: count unchanged, win_base += 1.
- Wrap-around: addresses wrap mod 2^ADDR_BITS; 0xFFF followed by 0x000 is sequential. flash_addr is recomputed only at start, so the flash stream continues linearly past FLASH_BASE+0xFFF. The window therefore never spans the wrap: when win_base+count would pass 0xFFF, the block stops and restarts at 0x000 on demand.
- Simultaneous miss and capture: capture is discarded; stop takes priority.
- Reset mid-operation: all state returns to reset values immediately. No flash_stop is issued; the controller shares the reset.

Optional Feature:
- Macro: ROM_PREFETCH_STATS_EN.
- When defined, adds output ports hit_count[15:0] and miss_count[15:0]:
  - Saturating counters, reset to 0.
  - hit_count increments on each cycle with hit.
  - miss_count increments on each flash_start.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Cold miss: reset, then rom_read=1, rom_address=0xFFC.
  - Required: flash_start pulses with flash_addr=0x100FFC; rom_wait=1 until the first byte (0xA5) is captured; rom_data=0xA5 one cycle after rom_wait falls.
- Sequential hits: after 4 bytes are captured (0xFFC..0xFFF), read 0xFFC,0xFFD,0xFFE,0xFFF.
  - Required: rom_wait=0 each cycle; data correct with 1-cycle latency; no further flash_start.
- Full/slide: DEPTH=4 with the window full.
  - Required: flash_stall=1. A hit at offset 1 gives win_base+1, count=3, flash_stall=0 the next cycle; the next byte lands in the freed slot.
- Jump miss during FILL: window base 0x100, read 0x800.
  - Required: flash_stop pulse; no start while flash_busy=1; flash_start with flash_addr=0x100800 the cycle after busy falls.
- Wrap: stream reaching 0xFFF, then read 0x000.
  - Required: miss, stop, then restart with flash_addr=0x100000.
- Reset mid-FILL (count=2), then a repeat read of the same address.
  - Required: the cycle after reset, count=0 and all flash controls are 0; the read causes a fresh flash_start. With ROM_PREFETCH_STATS_EN defined, miss_count=1 after reset.
